mem_bus_arbiter: RTL and testbench

Two-requester arbiter that shares the single external memory bus between the IF stage (instruction fetch) and the MEM stage (load/store issued from the EX/MEM pipeline register). Requests are granted one at a time; read data is returned registered, and a one-cycle done pulse goes to the requester. A combinational stall request goes to pipeline control while any access is outstanding, and a watchdog ends any bus access that is never acknowledged.

---
 rtl/mem_bus_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_bus_arbiter
//  Description : Shares one external memory bus between instruction fetch
//                (IF) and load/store (MEM). One grant at a time, registered
//                read data with a one-cycle done pulse, combinational stall
//                request and a watchdog for unacknowledged accesses.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    // instruction fetch requester
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    // load/store requester
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [3:0]        mem_be,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_done,
    // external memory bus
    output logic              bus_req,
    output logic              bus_we,
    output logic [3:0]        bus_be,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ack,
    // pipeline control
    output logic              stall_req,
    output logic              bus_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GNT_MEM = 2'd1,
        GNT_IF  = 2'd2
    } state_t;

    // Last timer value a grant may reach before the watchdog fires.
    localparam logic [3:0] c_timer_last = 4'(TIMEOUT - 1);

    state_t              r_state;
    state_t              w_next_state;
    logic                r_skip_if;
    logic [3:0]          r_timer;

    logic                r_bus_req;
    logic                r_bus_we;
    logic [3:0]          r_bus_be;
    logic [ADDR_W-1:0]   r_bus_addr;
    logic [DATA_W-1:0]   r_bus_wdata;
    logic [DATA_W-1:0]   r_if_rdata;
    logic [DATA_W-1:0]   r_mem_rdata;
    logic                r_if_done;
    logic                r_mem_done;
    logic                r_bus_err;

    logic                w_if_elig;
    logic                w_mem_elig;
    logic                w_grant_mem;
    logic                w_grant_if;
    logic                w_timer_last;
    logic                w_leave;
    logic                w_expire;
    logic [DATA_W-1:0]   w_cap_data;

    // A requester in its done cycle is still holding req for the access that
    // just finished, so it must not be granted again.
    assign w_if_elig    = if_req  & ~r_if_done;
    assign w_mem_elig   = mem_req & ~r_mem_done;
    assign w_timer_last = (r_timer == c_timer_last);
    assign w_leave      = (r_state != IDLE) & (bus_ack | w_timer_last);
    assign w_expire     = (r_state != IDLE) & ~bus_ack & w_timer_last;
    assign w_cap_data   = bus_ack ? bus_rdata : '0;

    // Next-state and grant decode; MEM has priority unless IF was already passed over once.
    always_comb begin
        w_next_state = r_state;
        w_grant_mem  = 1'b0;
        w_grant_if   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_mem_elig && !(r_skip_if && w_if_elig)) begin
                    w_next_state = GNT_MEM;
                    w_grant_mem  = 1'b1;
                end else if (w_if_elig) begin
                    w_next_state = GNT_IF;
                    w_grant_if   = 1'b1;
                end
            end
            GNT_MEM, GNT_IF: begin
                if (bus_ack || w_timer_last) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // State register, IF-fairness flag and per-grant watchdog timer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_skip_if <= 1'b0;
            r_timer   <= 4'd0;
        end else begin
            r_state <= w_next_state;
            if (w_grant_mem && if_req) begin
                r_skip_if <= 1'b1;
            end else if (w_grant_if) begin
                r_skip_if <= 1'b0;
            end
            if (r_state != IDLE && w_next_state != IDLE) begin
                r_timer <= r_timer + 4'd1;
            end else begin
                r_timer <= 4'd0;
            end
        end
    end

    // Latch the granted access so the bus stays stable whatever the requesters do.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_be    <= 4'd0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
        end else begin
            r_bus_req <= (w_next_state != IDLE);
            if (w_grant_mem) begin
                r_bus_we    <= mem_we;
                r_bus_be    <= mem_be;
                r_bus_addr  <= mem_addr;
                r_bus_wdata <= mem_wdata;
            end else if (w_grant_if) begin
                r_bus_we    <= 1'b0;
                r_bus_be    <= 4'hF;
                r_bus_addr  <= if_addr;
                r_bus_wdata <= '0;
            end
        end
    end

    // Completion: capture read data (zero on watchdog expiry) and pulse done/err.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_if_rdata  <= '0;
            r_mem_rdata <= '0;
            r_if_done   <= 1'b0;
            r_mem_done  <= 1'b0;
            r_bus_err   <= 1'b0;
        end else begin
            r_if_done  <= w_leave & (r_state == GNT_IF);
            r_mem_done <= w_leave & (r_state == GNT_MEM);
            r_bus_err  <= w_expire;
            if (w_leave && r_state == GNT_IF) begin
                r_if_rdata <= w_cap_data;
            end
            if (w_leave && r_state == GNT_MEM) begin
                r_mem_rdata <= w_cap_data;
            end
        end
    end

    assign bus_req   = r_bus_req;
    assign bus_we    = r_bus_we;
    assign bus_be    = r_bus_be;
    assign bus_addr  = r_bus_addr;
    assign bus_wdata = r_bus_wdata;
    assign if_rdata  = r_if_rdata;
    assign mem_rdata = r_mem_rdata;
    assign if_done   = r_if_done;
    assign mem_done  = r_mem_done;
    assign bus_err   = r_bus_err;
    assign stall_req = (if_req & ~r_if_done) | (mem_req & ~r_mem_done);

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_bus_arbiter
//  Description : Self-checking bench for mem_bus_arbiter: directed scenarios
//                plus randomized traffic against a transaction-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_bus_arbiter;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 15;

    logic              clk = 1'b0;
    logic              reset;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_done;
    logic              mem_req;
    logic              mem_we;
    logic [3:0]        mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_done;
    logic              bus_req;
    logic              bus_we;
    logic [3:0]        bus_be;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic [DATA_W-1:0] bus_rdata;
    logic              bus_ack;
    logic              stall_req;
    logic              bus_err;

    int checks = 0;
    int errors = 0;

    mem_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done),
        .bus_req(bus_req), .bus_we(bus_we), .bus_be(bus_be), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
        .stall_req(stall_req), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; if_req = 0; if_addr = 0; mem_req = 0; mem_we = 0; mem_be = 0;
        mem_addr = 0; mem_wdata = 0; bus_rdata = 0; bus_ack = 0;
        tick; tick;
        checks++; if ({if_done, mem_done, bus_req, bus_we, bus_err} !== 5'b0) begin errors++; $display("FAIL reset_ctrl: got %b expected 00000", {if_done, mem_done, bus_req, bus_we, bus_err}); end
        checks++; if (bus_addr !== 32'h0 || bus_wdata !== 32'h0 || bus_be !== 4'h0) begin errors++; $display("FAIL reset_bus: got addr %h wdata %h be %h expected zeros", bus_addr, bus_wdata, bus_be); end
        checks++; if (if_rdata !== 32'h0 || mem_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h/%h expected 0/0", if_rdata, mem_rdata); end
        reset = 1'b0;
        tick;
        checks++; if (stall_req !== 1'b0 || bus_req !== 1'b0) begin errors++; $display("FAIL reset_idle: got stall %b bus_req %b expected 0 0", stall_req, bus_req); end
    endtask

    task automatic test_if_fetch;
        if_req = 1'b1; if_addr = 32'h0000_0040;
        tick;
        checks++; if (bus_req !== 1'b1 || bus_addr !== 32'h40 || bus_we !== 1'b0 || bus_be !== 4'hF) begin errors++; $display("FAIL fetch_grant: got req %b addr %h we %b be %h expected 1 40 0 f", bus_req, bus_addr, bus_we, bus_be); end
        checks++; if (stall_req !== 1'b1 || if_done !== 1'b0) begin errors++; $display("FAIL fetch_stall: got stall %b done %b expected 1 0", stall_req, if_done); end
        bus_ack = 1'b1; bus_rdata = 32'h2002_0005;
        tick;
        bus_ack = 1'b0; bus_rdata = 32'h0;
        checks++; if (if_done !== 1'b1 || if_rdata !== 32'h2002_0005) begin errors++; $display("FAIL fetch_done: got done %b rdata %h expected 1 20020005", if_done, if_rdata); end
        checks++; if (bus_req !== 1'b0 || stall_req !== 1'b0) begin errors++; $display("FAIL fetch_release: got bus_req %b stall %b expected 0 0", bus_req, stall_req); end
        // if_req still held during the done cycle: must not be re-granted
        tick;
        checks++; if (bus_req !== 1'b0 || if_done !== 1'b0) begin errors++; $display("FAIL hold_no_regrant: got bus_req %b done %b expected 0 0", bus_req, if_done); end
        if_req = 1'b0;
        tick;
    endtask

    task automatic test_store;
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h100; mem_be = 4'b0011; mem_wdata = 32'hDEAD_BEEF;
        tick;
        mem_we = 1'b0; mem_addr = 32'hFFFF_FFF0; mem_be = 4'hC; mem_wdata = 32'h0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (bus_req !== 1'b1 || bus_we !== 1'b1 || bus_be !== 4'h3 || bus_addr !== 32'h100 || bus_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL store_bus[%0d]: got req %b we %b be %h addr %h wdata %h expected 1 1 3 100 deadbeef", i, bus_req, bus_we, bus_be, bus_addr, bus_wdata); end
            checks++; if (mem_done !== 1'b0) begin errors++; $display("FAIL store_early_done[%0d]: got %b expected 0", i, mem_done); end
            if (i == 2) begin bus_ack = 1'b1; bus_rdata = 32'h0BAD_F00D; end
            tick;
        end
        bus_ack = 1'b0;
        checks++; if (mem_done !== 1'b1 || bus_req !== 1'b0) begin errors++; $display("FAIL store_done: got done %b bus_req %b expected 1 0", mem_done, bus_req); end
        mem_req = 1'b0;
        tick;
        checks++; if (stall_req !== 1'b0 || mem_done !== 1'b0 || bus_req !== 1'b0) begin errors++; $display("FAIL store_after: got stall %b done %b bus_req %b expected 0 0 0", stall_req, mem_done, bus_req); end
    endtask

    task automatic test_simultaneous;
        if_req = 1'b1; if_addr = 32'h200; mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h300;
        tick;
        checks++; if (bus_req !== 1'b1 || bus_addr !== 32'h300) begin errors++; $display("FAIL simul_mem_first: got req %b addr %h expected 1 300", bus_req, bus_addr); end
        bus_ack = 1'b1; bus_rdata = 32'h1111_1111;
        tick;
        bus_ack = 1'b0;
        checks++; if (mem_done !== 1'b1 || mem_rdata !== 32'h1111_1111 || bus_req !== 1'b0) begin errors++; $display("FAIL simul_mem_done: got done %b rdata %h bus_req %b expected 1 11111111 0", mem_done, mem_rdata, bus_req); end
        mem_addr = 32'h304; // MEM issues its next access straight away
        tick;
        checks++; if (bus_req !== 1'b1 || bus_addr !== 32'h200 || bus_be !== 4'hF || bus_we !== 1'b0) begin errors++; $display("FAIL simul_if_next: got req %b addr %h be %h we %b expected 1 200 f 0", bus_req, bus_addr, bus_be, bus_we); end
        bus_ack = 1'b1; bus_rdata = 32'h2222_2222;
        tick;
        bus_ack = 1'b0;
        checks++; if (if_done !== 1'b1 || if_rdata !== 32'h2222_2222 || mem_rdata !== 32'h1111_1111) begin errors++; $display("FAIL simul_if_done: got done %b if_rdata %h mem_rdata %h expected 1 22222222 11111111", if_done, if_rdata, mem_rdata); end
        if_req = 1'b0;
        tick;
        checks++; if (bus_req !== 1'b1 || bus_addr !== 32'h304) begin errors++; $display("FAIL simul_mem_again: got req %b addr %h expected 1 304", bus_req, bus_addr); end
        bus_ack = 1'b1; bus_rdata = 32'h3333_3333;
        tick;
        bus_ack = 1'b0;
        checks++; if (mem_done !== 1'b1 || mem_rdata !== 32'h3333_3333) begin errors++; $display("FAIL simul_mem2_done: got done %b rdata %h expected 1 33333333", mem_done, mem_rdata); end
        mem_req = 1'b0;
        tick;
    endtask

    task automatic test_timeout;
        int hi;
        hi = 0;
        if_req = 1'b1; if_addr = 32'h80; bus_ack = 1'b0;
        tick;
        for (int i = 0; i < 40 && bus_req === 1'b1; i++) begin
            hi++;
            tick;
        end
        checks++; if (hi !== TIMEOUT) begin errors++; $display("FAIL timeout_len: got %0d cycles expected %0d", hi, TIMEOUT); end
        checks++; if (if_done !== 1'b1 || bus_err !== 1'b1) begin errors++; $display("FAIL timeout_pulse: got done %b err %b expected 1 1", if_done, bus_err); end
        checks++; if (if_rdata !== 32'h0) begin errors++; $display("FAIL timeout_rdata: got %h expected 0", if_rdata); end
        if_req = 1'b0;
        tick;
        checks++; if (bus_err !== 1'b0 || if_done !== 1'b0) begin errors++; $display("FAIL timeout_one_shot: got err %b done %b expected 0 0", bus_err, if_done); end
    endtask

    task automatic test_reset_mid_grant;
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h400; mem_wdata = 32'hA5A5_A5A5; mem_be = 4'hF;
        tick; tick;
        checks++; if (bus_req !== 1'b1 || bus_addr !== 32'h400) begin errors++; $display("FAIL rst_mid_pre: got req %b addr %h expected 1 400", bus_req, bus_addr); end
        #2 reset = 1'b1;
        #1;
        checks++; if (bus_req !== 1'b0 || bus_addr !== 32'h0 || bus_wdata !== 32'h0 || bus_we !== 1'b0 || bus_be !== 4'h0) begin errors++; $display("FAIL rst_mid_async: got req %b addr %h wdata %h we %b be %h expected zeros", bus_req, bus_addr, bus_wdata, bus_we, bus_be); end
        checks++; if (mem_done !== 1'b0 || bus_err !== 1'b0 || mem_rdata !== 32'h0) begin errors++; $display("FAIL rst_mid_outputs: got done %b err %b rdata %h expected 0 0 0", mem_done, bus_err, mem_rdata); end
        tick;
        mem_we = 1'b0; mem_addr = 32'h500;
        checks++; if (mem_done !== 1'b0 || bus_req !== 1'b0) begin errors++; $display("FAIL rst_mid_hold: got done %b req %b expected 0 0", mem_done, bus_req); end
        reset = 1'b0;
        tick;
        checks++; if (bus_req !== 1'b1 || bus_addr !== 32'h500 || bus_we !== 1'b0) begin errors++; $display("FAIL rst_mid_regrant: got req %b addr %h we %b expected 1 500 0", bus_req, bus_addr, bus_we); end
        bus_ack = 1'b1; bus_rdata = 32'h4444_4444;
        tick;
        bus_ack = 1'b0;
        checks++; if (mem_done !== 1'b1 || mem_rdata !== 32'h4444_4444) begin errors++; $display("FAIL rst_mid_done: got done %b rdata %h expected 1 44444444", mem_done, mem_rdata); end
        mem_req = 1'b0;
        tick;
    endtask

    // Randomized traffic. The model tracks who owns the bus, how long the
    // current access has waited, and the fairness rule, one transaction at a time.
    task automatic test_random;
        int                m_owner;   // 0 none, 1 MEM, 2 IF
        int                m_elapsed;
        bit                m_skip;
        logic [ADDR_W-1:0] e_addr;
        logic              e_we;
        logic [3:0]        e_be;
        logic [DATA_W-1:0] e_wdata;
        logic              e_if_done, e_mem_done, e_err;
        logic [DATA_W-1:0] e_if_rdata, e_mem_rdata;
        logic              e_stall;
        int                ack_left;
        bit                prev_req, ie, me;
        int                completes;

        reset = 1'b1; if_req = 0; mem_req = 0; bus_ack = 0;
        tick;
        reset = 1'b0;
        m_owner = 0; m_elapsed = 0; m_skip = 0;
        e_addr = 0; e_we = 0; e_be = 0; e_wdata = 0;
        e_if_done = 0; e_mem_done = 0; e_err = 0; e_if_rdata = 0; e_mem_rdata = 0;
        ack_left = 0; prev_req = 0; completes = 0;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            e_stall = (if_req & ~e_if_done) | (mem_req & ~e_mem_done);
            checks++; if ({bus_req, if_done, mem_done, bus_err} !== {m_owner != 0, e_if_done, e_mem_done, e_err}) begin errors++; $display("FAIL rnd_ctrl@%0d: got req/ifd/memd/err %b expected %b", cyc, {bus_req, if_done, mem_done, bus_err}, {m_owner != 0, e_if_done, e_mem_done, e_err}); end
            checks++; if (if_rdata !== e_if_rdata || mem_rdata !== e_mem_rdata) begin errors++; $display("FAIL rnd_rdata@%0d: got %h/%h expected %h/%h", cyc, if_rdata, mem_rdata, e_if_rdata, e_mem_rdata); end
            checks++; if (stall_req !== e_stall) begin errors++; $display("FAIL rnd_stall@%0d: got %b expected %b", cyc, stall_req, e_stall); end
            if (m_owner != 0) begin
                checks++; if (bus_addr !== e_addr || bus_we !== e_we || bus_be !== e_be || (m_owner == 1 && bus_wdata !== e_wdata)) begin errors++; $display("FAIL rnd_fields@%0d: got addr %h we %b be %h wdata %h expected %h %b %h %h", cyc, bus_addr, bus_we, bus_be, bus_wdata, e_addr, e_we, e_be, e_wdata); end
            end

            // requesters: hold until done, sometimes issue the next one at once
            if (if_req) begin
                if (if_done) if_req = ($urandom % 4 == 0);
            end else begin
                if_req = ($urandom % 2 == 0);
            end
            if (mem_req) begin
                if (mem_done) mem_req = ($urandom % 4 == 0);
            end else begin
                mem_req = ($urandom % 2 == 0);
            end
            if_addr = $urandom; mem_addr = $urandom; mem_we = 1'($urandom);
            mem_be = 4'($urandom); mem_wdata = $urandom;

            // bus responder: 0..3 wait cycles, occasionally never answers
            if (bus_req && !prev_req) ack_left = ($urandom % 8 == 0) ? 100 : int'($urandom % 4);
            prev_req  = bus_req;
            bus_rdata = $urandom;
            if (bus_req) begin
                bus_ack = (ack_left == 0);
                ack_left--;
            end else begin
                bus_ack = ($urandom % 4 == 0);
            end

            // model step: what the outputs must be after this edge
            ie = if_req & ~e_if_done;
            me = mem_req & ~e_mem_done;
            e_if_done = 0; e_mem_done = 0; e_err = 0;
            if (m_owner == 0) begin
                if (me && !(m_skip && ie)) begin
                    m_owner = 1; e_addr = mem_addr; e_we = mem_we; e_be = mem_be; e_wdata = mem_wdata;
                    if (if_req) m_skip = 1;
                end else if (ie) begin
                    m_owner = 2; e_addr = if_addr; e_we = 0; e_be = 4'hF;
                    m_skip = 0;
                end
                m_elapsed = 0;
            end else if (bus_ack || m_elapsed == TIMEOUT - 1) begin
                if (m_owner == 1) begin e_mem_done = 1; e_mem_rdata = bus_ack ? bus_rdata : '0; end
                else begin e_if_done = 1; e_if_rdata = bus_ack ? bus_rdata : '0; end
                e_err = ~bus_ack;
                m_owner = 0;
                completes++;
            end else begin
                m_elapsed++;
            end
            tick;
        end
        checks++; if (completes < 200) begin errors++; $display("FAIL rnd_activity: got %0d completions expected at least 200", completes); end
        if_req = 0; mem_req = 0; bus_ack = 0;
        tick;
    endtask

    initial begin
        reset = 1'b1; if_req = 0; if_addr = 0; mem_req = 0; mem_we = 0; mem_be = 0;
        mem_addr = 0; mem_wdata = 0; bus_rdata = 0; bus_ack = 0;
        test_reset;
        test_if_fetch;
        test_store;
        test_simultaneous;
        test_timeout;
        test_reset_mid_grant;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
